dwt_pass_scheduler: RTL and testbench
=====================================

Name: dwt_pass_scheduler

Overview:
Sequencer for the 2D DWT lifting/MAC datapath. Issues read-pointer pairs for each row pass (mode 0) and column pass (mode 1) at each decomposition level, with ready/valid backpressure from the MAC. Between passes it waits for in-flight write-backs to drain, then flips the ping-pong bank select. Signals done once all levels are complete. Sits between top-level start/done control and the memory/MAC address generators.

Parameters:
HEIGHT, 256, image rows; power of two, >=4
WIDTH, 256, image columns; power of two, >=4
DECOMPOSITION_LEVEL, 1, number of levels (1..7)
MAX_INFLIGHT, 8, maximum issued-but-not-written-back pairs; power of two

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begins a full transform when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the transform completes
o_rd_valid  out  1  pointer pair valid
i_rd_ready  in  1  MAC accepts pair
o_mode  out  1  0 = row pass, 1 = column pass; also the bank select
o_level  out  3  current level
o_row_column_pointer  out  $clog2(WIDTH)  row (mode 0) or column (mode 1) index
o_pixel_pointer  out  $clog2(WIDTH)  even index of the first sample in the pair
o_last_pixel  out  1  high with the final pair of a row/column
i_wb_valid  in  1  one pair written back this cycle
o_pass_done  out  1  one-cycle pulse at each pass switch
o_err  out  1  sticky; write-back with zero outstanding

Behaviour:
- Reset: state IDLE; all outputs 0; pointers, level, mode and outstanding count cleared. Reset mid-transform aborts immediately; no done pulse.
- Limits: mode 0: PL = WIDTH>>level, RL = HEIGHT>>level. Mode 1: PL = HEIGHT>>level, RL = WIDTH>>level.
- States: IDLE, ISSUE, DRAIN, SWITCH, DONE.
- IDLE:
  - On start: clear level and mode, go to ISSUE; busy=1 next cycle.
  - start is ignored in any other state.
- ISSUE:
  - o_rd_valid=1 when outstanding<MAX_INFLIGHT, else 0 (stall).
  - Pointers, o_last_pixel and o_mode are held stable while valid && !ready.
  - On transfer: pixel_pointer+=2. At pixel_pointer==PL-2, pixel_pointer wraps to 0 and row_column_pointer+=1.
  - o_last_pixel = (pixel_pointer==PL-2), combinational from the current pointers.
  - Transfer with pixel_pointer==PL-2 and row_column_pointer==RL-1 is the last of the pass: both pointers go to 0, next state DRAIN.
- Outstanding counter: +1 on transfer, -1 on i_wb_valid; both in the same cycle means no change. i_wb_valid at 0 sets o_err, and the count stays 0.
- DRAIN: o_rd_valid=0; wait for outstanding==0, then go to SWITCH.
- SWITCH (1 cycle): o_pass_done=1.
  - Mode 0: mode<=1, go to ISSUE.
  - Mode 1, level==DECOMPOSITION_LEVEL-1: go to DONE.
  - Mode 1, otherwise: mode<=0, level+=1, go to ISSUE.
- DONE (1 cycle): done=1, busy<=0, return to IDLE. o_level holds its final value until the next start.
- Pairs per pass at level L: (PL/2)*RL.
- No combinational path from i_rd_ready to o_rd_valid.

Optional Feature:
DWT_PASS_PERF_EN
- Defined: adds output o_stall_cycles (32 bits).
  - Increments each cycle in ISSUE/DRAIN where no pair transfers.
  - Saturates at 0xFFFFFFFF.
  - Clears on accepted start and on rst.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. H=W=8, LEVEL=2, ready tied 1, write-back 2 cycles after each issue. Expect 32+32+8+8=80 transfers and 4 pass_done pulses; mode sequence 0,1,0,1; level sequence 0,0,1,1; one done pulse; busy low afterwards.
2. Same config, ready toggling every other cycle. Pointers stay stable during stalls, transfer count is still 80, and the pixel_pointer sequence in the level-1 row pass is 0,2,0,2...
3. MAX_INFLIGHT=4, write-backs withheld. o_rd_valid drops after 4 transfers; releasing one write-back allows exactly one more transfer. A simultaneous issue and write-back keeps the count at 4.
4. Last pair of the first pass issued, write-backs delayed 10 cycles. Scheduler stays in DRAIN with valid=0, and pass_done fires exactly 1 cycle after the count reaches 0.
5. rst asserted mid column pass. All outputs are 0 next cycle with no done pulse; a new start runs a full 80-transfer sequence.
6. i_wb_valid pulsed while idle: o_err=1 and stays high until rst. With DWT_PASS_PERF_EN and ready held low for 5 cycles in test 2, o_stall_cycles is 5 or more.

Source files
------------

// File: rtl/dwt_pass_scheduler.sv
// dwt_pass_scheduler
// Sequencer for the 2D DWT lifting/MAC datapath. For every decomposition
// level it issues read-pointer pairs for a row pass (mode 0) then a column
// pass (mode 1), honouring ready/valid backpressure and a cap on in-flight
// pairs. Between passes it drains outstanding write-backs, then flips the
// ping-pong bank (o_mode). Pulses done after the final column pass.
// Optional feature: define DWT_PASS_PERF_EN to add the 32-bit saturating
// o_stall_cycles counter.
module dwt_pass_scheduler #(
  parameter int HEIGHT              = 256,
  parameter int WIDTH               = 256,
  parameter int DECOMPOSITION_LEVEL = 1,
  parameter int MAX_INFLIGHT        = 8,
  localparam int PW                 = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic          o_mode,
  output logic [2:0]    o_level,
  output logic [PW-1:0] o_row_column_pointer,
  output logic [PW-1:0] o_pixel_pointer,
  output logic          o_last_pixel,
  input  logic          i_wb_valid,
  output logic          o_pass_done,
  output logic          o_err
`ifdef DWT_PASS_PERF_EN
  ,
  output logic [31:0]   o_stall_cycles
`endif
);

  // Internal pointers are sized for the larger image dimension so a column
  // pass on a tall image still fits.
  localparam int IW = $clog2((HEIGHT > WIDTH) ? HEIGHT : WIDTH);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  localparam logic [IW:0]   H_FULL     = (IW+1)'(HEIGHT);
  localparam logic [IW:0]   W_FULL     = (IW+1)'(WIDTH);
  localparam logic [CW-1:0] CAP        = CW'(MAX_INFLIGHT);
  localparam logic [2:0]    LAST_LEVEL = 3'(DECOMPOSITION_LEVEL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_SWITCH,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] pix_ptr;
  logic [IW-1:0] rc_ptr;
  logic [CW-1:0] outstanding;
  logic [IW:0]   pix_limit;
  logic [IW:0]   rc_limit;
  logic          last_pix;
  logic          last_rc;
  logic          xfer;

  // Pass extents at the current level: a row pass walks WIDTH along HEIGHT
  // rows, a column pass walks HEIGHT along WIDTH columns.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    pix_limit = W_FULL >> o_level;
    rc_limit  = H_FULL >> o_level;
    if (o_mode) begin
      pix_limit = H_FULL >> o_level;
      rc_limit  = W_FULL >> o_level;
    end
  end

  assign last_pix = ({1'b0, pix_ptr} == pix_limit - (IW+1)'(2));
  assign last_rc  = ({1'b0, rc_ptr} == rc_limit - (IW+1)'(1));

  // Valid depends only on registered state, never on i_rd_ready.
  assign o_rd_valid           = (state == S_ISSUE) && (outstanding < CAP);
  assign xfer                 = o_rd_valid && i_rd_ready;
  assign o_last_pixel         = (state == S_ISSUE) && last_pix;
  assign o_pixel_pointer      = pix_ptr[PW-1:0];
  assign o_row_column_pointer = rc_ptr[PW-1:0];

  // Pass sequencing FSM plus the outstanding write-back tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of its neighbours.
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      o_pass_done <= 1'b0;
      o_err       <= 1'b0;
      o_mode      <= 1'b0;
      o_level     <= 3'd0;
      pix_ptr     <= '0;
      rc_ptr      <= '0;
      outstanding <= '0;
    end else begin
      done        <= 1'b0;
      o_pass_done <= 1'b0;

      // A transfer and a write-back in the same cycle cancel out.
      case ({xfer, i_wb_valid})
        2'b10: outstanding <= outstanding + CW'(1);
        2'b01: begin
          if (outstanding != '0) outstanding <= outstanding - CW'(1);
          else                   o_err       <= 1'b1;
        end
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ISSUE;
            busy    <= 1'b1;
            o_mode  <= 1'b0;
            o_level <= 3'd0;
            pix_ptr <= '0;
            rc_ptr  <= '0;
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            if (last_pix) begin
              pix_ptr <= '0;
              if (last_rc) begin
                rc_ptr <= '0;
                state  <= S_DRAIN;
              end else begin
                rc_ptr <= rc_ptr + IW'(1);
              end
            end else begin
              pix_ptr <= pix_ptr + IW'(2);
            end
          end
        end
        S_DRAIN: begin
          if (outstanding == '0) begin
            state       <= S_SWITCH;
            o_pass_done <= 1'b1;
          end
        end
        S_SWITCH: begin
          if (!o_mode) begin
            o_mode <= 1'b1;
            state  <= S_ISSUE;
          end else if (o_level == LAST_LEVEL) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            o_mode  <= 1'b0;
            o_level <= o_level + 3'd1;
            state   <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DWT_PASS_PERF_EN
  // Saturating count of ISSUE/DRAIN cycles in which no pair moved.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      o_stall_cycles <= '0;
    end else if ((state == S_ISSUE || state == S_DRAIN) && !xfer &&
                 o_stall_cycles != 32'hFFFF_FFFF) begin
      o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dwt_pass_scheduler.sv
// Self-checking bench for dwt_pass_scheduler (8x8 image, 2 levels, 4 in flight).
// Expected pair streams come from a nested-loop model of the pass geometry;
// observed pairs, pass_done and done pulses are collected every cycle.
module tb_dwt_pass_scheduler;

  localparam int H  = 8;
  localparam int W  = 8;
  localparam int LV = 2;
  localparam int MI = 4;
  localparam int PW = $clog2(W);
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          i_rd_ready = 1'b0;
  logic          i_wb_valid = 1'b0;
  logic          busy, done, o_rd_valid, o_mode, o_last_pixel, o_pass_done, o_err;
  logic [2:0]    o_level;
  logic [PW-1:0] o_row_column_pointer, o_pixel_pointer;
`ifdef DWT_PASS_PERF_EN
  logic [31:0]   o_stall_cycles;
`endif

  always #5 clk = ~clk;

  dwt_pass_scheduler #(
    .HEIGHT(H), .WIDTH(W), .DECOMPOSITION_LEVEL(LV), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_mode(o_mode),
    .o_level(o_level), .o_row_column_pointer(o_row_column_pointer),
    .o_pixel_pointer(o_pixel_pointer), .o_last_pixel(o_last_pixel),
    .i_wb_valid(i_wb_valid), .o_pass_done(o_pass_done), .o_err(o_err)
`ifdef DWT_PASS_PERF_EN
    , .o_stall_cycles(o_stall_cycles)
`endif
  );

  typedef struct packed {
    logic          mode;
    logic [2:0]    level;
    logic [PW-1:0] rc;
    logic [PW-1:0] pp;
    logic          last;
  } rec_t;

  typedef struct packed {
    logic       mode;
    logic [2:0] level;
  } pass_t;

  rec_t  exp_q[$];
  rec_t  obs_q[$];
  pass_t exp_pd[$];
  pass_t pd_q[$];
  int    wb_due[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt, busy_cyc, viol, drain_viol;
  int last_wb_cyc, first_pd_cyc, first_pd_wb, t32;
  bit prev_hold;
  rec_t prev_rec;

  int rdy_mode = 0;   // 0 high, 1 toggle, 2 random, 3 low
  bit wb_hold = 1'b0;
  int wb_lo = 2;
  int wb_hi = 2;
  int wb_force = 0;

  // Reference model: enumerate every pair of every pass from the geometry.
  function automatic void build_expected();
    exp_q.delete();
    exp_pd.delete();
    for (int lv = 0; lv < LV; lv++) begin
      for (int m = 0; m < 2; m++) begin
        int pl = ((m == 0) ? W : H) >> lv;
        int rl = ((m == 0) ? H : W) >> lv;
        pass_t ps;
        ps.mode  = m[0];
        ps.level = lv[2:0];
        exp_pd.push_back(ps);
        for (int r = 0; r < rl; r++) begin
          for (int p = 0; p < pl; p += 2) begin
            rec_t e;
            e.mode  = m[0];
            e.level = lv[2:0];
            e.rc    = r[PW-1:0];
            e.pp    = p[PW-1:0];
            e.last  = (p == pl - 2);
            exp_q.push_back(e);
          end
        end
      end
    end
  endfunction

  function automatic int seq_errors();
    int n = 0;
    if (obs_q.size() != exp_q.size()) n++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  function automatic int pd_errors();
    int n = 0;
    if (pd_q.size() != exp_pd.size()) n++;
    for (int i = 0; i < pd_q.size() && i < exp_pd.size(); i++)
      if (pd_q[i] !== exp_pd[i]) n++;
    return n;
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    pd_q.delete();
    done_cnt = 0; busy_cyc = 0; viol = 0; drain_viol = 0;
    last_wb_cyc = -1; first_pd_cyc = -1; first_pd_wb = -1; t32 = -1;
    prev_hold = 1'b0;
  endtask

  // One clock: sample at the falling edge, drive 1 time unit after the rise.
  task automatic step();
    rec_t cur;
    @(negedge clk);
    cur = {o_mode, o_level, o_row_column_pointer, o_pixel_pointer, o_last_pixel};
    if (prev_hold && cur !== prev_rec) viol++;
    prev_hold = o_rd_valid && !i_rd_ready;
    prev_rec  = cur;
    if (o_rd_valid && obs_q.size() >= 32 && pd_q.size() == 0) drain_viol++;
    if (o_rd_valid && i_rd_ready) begin
      obs_q.push_back(cur);
      wb_due.push_back(cyc + int'($urandom_range(wb_hi, wb_lo)));
      if (obs_q.size() == 32) t32 = cyc;
    end
    if (o_pass_done) begin
      if (pd_q.size() == 0) begin
        first_pd_cyc = cyc;
        first_pd_wb  = last_wb_cyc;
      end
      pd_q.push_back({o_mode, o_level});
    end
    if (done) done_cnt++;
    if (busy) busy_cyc++;

    @(posedge clk);
    #1;
    cyc++;
    if (rst) prev_hold = 1'b0;
    case (rdy_mode)
      0:       i_rd_ready = 1'b1;
      1:       i_rd_ready = cyc[0];
      2:       i_rd_ready = 1'($urandom_range(1, 0));
      default: i_rd_ready = 1'b0;
    endcase
    i_wb_valid = 1'b0;
    if (wb_force > 0) begin
      i_wb_valid = 1'b1;
      wb_force--;
      if (wb_due.size() > 0) void'(wb_due.pop_front());
    end else if (!wb_hold && wb_due.size() > 0 && wb_due[0] <= cyc) begin
      i_wb_valid = 1'b1;
      void'(wb_due.pop_front());
    end
    if (i_wb_valid) last_wb_cyc = cyc;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; wb_force = 0;
    step(); step();
    rst = 1'b0;
    wb_due.delete();
    clear_obs();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit expired);
    expired = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      step();
      if (done_cnt > 0) begin
        expired = 1'b0;
        break;
      end
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, done, o_rd_valid, o_mode, o_level, o_row_column_pointer,
         o_pixel_pointer, o_last_pixel, o_pass_done, o_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b mode=%b level=%0d rc=%0d pp=%0d last=%b pd=%b err=%b, required all 0",
               busy, done, o_rd_valid, o_mode, o_level, o_row_column_pointer,
               o_pixel_pointer, o_last_pixel, o_pass_done, o_err);
    end
`ifdef DWT_PASS_PERF_EN
    checks++;
    if (o_stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall: got %0d required 0", o_stall_cycles);
    end
`endif
  endtask

  task automatic test_basic();
    bit exp_t;
    apply_reset();
    rdy_mode = 0; wb_hold = 1'b0; wb_lo = 2; wb_hi = 2;
    start_pulse();
    checks++;
    if (busy !== 1'b1 || o_rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_after_start: got busy=%b valid=%b required 1 1", busy, o_rd_valid);
    end
    wait_done(exp_t);
    checks++;
    if (exp_t) begin failures++; $display("FAIL basic_timeout: got no done required done within %0d", BUDGET); end
    checks++;
    if (obs_q.size() != 80) begin failures++; $display("FAIL basic_count: got %0d required 80", obs_q.size()); end
    checks++;
    if (seq_errors() != 0) begin failures++; $display("FAIL basic_sequence: got %0d bad pairs required 0", seq_errors()); end
    checks++;
    if (pd_errors() != 0) begin failures++; $display("FAIL basic_pass_done: got %0d pulses (%0d bad) required 4 (0,0)(1,0)(0,1)(1,1)", pd_q.size(), pd_errors()); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); end
    checks++;
    if (busy !== 1'b0 || o_level !== 3'(LV - 1)) begin
      failures++;
      $display("FAIL basic_idle_after: got busy=%b level=%0d required busy=0 level=%0d", busy, o_level, LV - 1);
    end
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b required 0", o_err); end
  endtask

  task automatic test_backpressure();
    bit exp_t;
    int bad;
    apply_reset();
    rdy_mode = 1; wb_hold = 1'b0; wb_lo = 2; wb_hi = 2;
    start_pulse();
    wait_done(exp_t);
    checks++;
    if (exp_t || seq_errors() != 0) begin
      failures++;
      $display("FAIL bp_sequence: got timeout=%b count=%0d bad=%0d required 0 80 0", exp_t, obs_q.size(), seq_errors());
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL bp_stable_pointers: got %0d changes during stall required 0", viol); end
    bad = 0;
    if (obs_q.size() < 72) bad = 1;
    else for (int i = 64; i < 72; i++) if (int'(obs_q[i].pp) != ((i - 64) % 2) * 2) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_level1_row_pp: got %0d wrong pointers required 0 (0,2,0,2...)", bad); end
`ifdef DWT_PASS_PERF_EN
    checks++;
    if (o_stall_cycles !== 32'(busy_cyc - pd_q.size() - done_cnt - obs_q.size()) || o_stall_cycles < 32'd5) begin
      failures++;
      $display("FAIL bp_stall_cycles: got %0d required %0d", o_stall_cycles,
               busy_cyc - pd_q.size() - done_cnt - obs_q.size());
    end
`endif
  endtask

  task automatic test_inflight();
    bit exp_t;
    apply_reset();
    rdy_mode = 0; wb_hold = 1'b1; wb_lo = 2; wb_hi = 2;
    start_pulse();
    repeat (10) step();
    checks++;
    if (obs_q.size() != 4 || o_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL inflight_cap: got %0d transfers valid=%b required 4 valid=0", obs_q.size(), o_rd_valid);
    end
    wb_force = 1;
    repeat (10) step();
    checks++;
    if (obs_q.size() != 5 || o_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL inflight_release_one: got %0d transfers valid=%b required 5 valid=0", obs_q.size(), o_rd_valid);
    end
    wb_force = 2;
    repeat (10) step();
    checks++;
    if (obs_q.size() != 7 || o_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL inflight_simultaneous: got %0d transfers valid=%b required 7 valid=0", obs_q.size(), o_rd_valid);
    end
    wb_force = 1;
    repeat (10) step();
    checks++;
    if (obs_q.size() != 8) begin failures++; $display("FAIL inflight_count_at_cap: got %0d transfers required 8", obs_q.size()); end
    wb_hold = 1'b0;
    wait_done(exp_t);
    checks++;
    if (exp_t || seq_errors() != 0) begin
      failures++;
      $display("FAIL inflight_sequence: got timeout=%b count=%0d bad=%0d required 0 80 0", exp_t, obs_q.size(), seq_errors());
    end
  endtask

  task automatic test_drain();
    bit exp_t;
    apply_reset();
    rdy_mode = 0; wb_hold = 1'b0; wb_lo = 10; wb_hi = 10;
    start_pulse();
    wait_done(exp_t);
    checks++;
    if (exp_t || seq_errors() != 0) begin
      failures++;
      $display("FAIL drain_sequence: got timeout=%b count=%0d bad=%0d required 0 80 0", exp_t, obs_q.size(), seq_errors());
    end
    checks++;
    if (drain_viol != 0) begin failures++; $display("FAIL drain_valid_low: got %0d valid cycles in drain required 0", drain_viol); end
    checks++;
    if (first_pd_cyc - first_pd_wb != 2 || first_pd_cyc - t32 != 12) begin
      failures++;
      $display("FAIL drain_pass_done_timing: got pd-lastwb=%0d pd-lastxfer=%0d required 2 12",
               first_pd_cyc - first_pd_wb, first_pd_cyc - t32);
    end
  endtask

  task automatic test_reset_mid();
    bit exp_t;
    bit reached = 1'b0;
    apply_reset();
    rdy_mode = 0; wb_hold = 1'b0; wb_lo = 2; wb_hi = 2;
    start_pulse();
    for (int i = 0; i < BUDGET && !reached; i++) begin
      step();
      reached = (obs_q.size() >= 40);
    end
    checks++;
    if (!reached || o_mode !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_in_column_pass: got reached=%b mode=%b required 1 1", reached, o_mode);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wb_due.delete();
    checks++;
    if ({busy, done, o_rd_valid, o_mode, o_level, o_row_column_pointer,
         o_pixel_pointer, o_last_pixel, o_pass_done, o_err} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got busy=%b valid=%b mode=%b level=%0d rc=%0d pp=%0d required all 0",
               busy, o_rd_valid, o_mode, o_level, o_row_column_pointer, o_pixel_pointer);
    end
    repeat (6) step();
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d done pulses required 0", done_cnt); end
    clear_obs();
    start_pulse();
    wait_done(exp_t);
    checks++;
    if (exp_t || seq_errors() != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL rstmid_rerun: got timeout=%b count=%0d bad=%0d done=%0d required 0 80 0 1",
               exp_t, obs_q.size(), seq_errors(), done_cnt);
    end
  endtask

  task automatic test_random();
    bit exp_t;
    apply_reset();
    rdy_mode = 2; wb_hold = 1'b0; wb_lo = 1; wb_hi = 6;
    start_pulse();
    repeat (20) step();
    start_pulse();  // must be ignored while busy
    wait_done(exp_t);
    checks++;
    if (exp_t || seq_errors() != 0) begin
      failures++;
      $display("FAIL random_sequence: got timeout=%b count=%0d bad=%0d required 0 80 0", exp_t, obs_q.size(), seq_errors());
    end
    checks++;
    if (done_cnt != 1 || pd_errors() != 0) begin
      failures++;
      $display("FAIL random_pulses: got done=%0d pass_done=%0d required 1 4", done_cnt, pd_q.size());
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL random_stable_pointers: got %0d required 0", viol); end
`ifdef DWT_PASS_PERF_EN
    checks++;
    if (o_stall_cycles !== 32'(busy_cyc - pd_q.size() - done_cnt - obs_q.size())) begin
      failures++;
      $display("FAIL random_stall_cycles: got %0d required %0d", o_stall_cycles,
               busy_cyc - pd_q.size() - done_cnt - obs_q.size());
    end
`endif
  endtask

  task automatic test_err();
    apply_reset();
    rdy_mode = 0;
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL err_initial: got %b required 0", o_err); end
    wb_force = 1;
    step(); step();
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b required 1", o_err); end
    repeat (5) step();
    checks++;
    if (o_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky: got err=%b busy=%b required 1 0", o_err, busy);
    end
    apply_reset();
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b required 0", o_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_expected();
    clear_obs();
    test_reset();
    test_basic();
    test_backpressure();
    test_inflight();
    test_drain();
    test_reset_mid();
    test_random();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
